amo_rmw_controller: RTL and testbench

Executes the single atomic request selected by the multi-core AMO arbiter as a sequenced read-modify-write on a shared memory port. Also maintains per-core LR/SC reservations and returns the original memory word, or the SC status, to the arbiter. Sits between the AMO arbiter output and the coherent memory/L2 port.

---
 rtl/amo_rmw_controller.sv | 183 ++++++++++++++++++
 tb/tb_amo_rmw_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_rmw_controller.sv
// Atomic read-modify-write sequencer with per-core LR/SC reservations.
// Optional feature macro: AMO_MINMAX_EN enables AMOMIN/MAX/MINU/MAXU.
module amo_rmw_controller #(
    parameter int XLEN           = 32,
    parameter int CORE_NUMS      = 4,
    parameter int CORE_NUMS_BITS = (CORE_NUMS == 1) ? 1 : $clog2(CORE_NUMS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CORE_NUMS_BITS-1:0] A_id_i,
    input  logic                      A_strobe_i,
    input  logic [XLEN-1:0]           A_addr_i,
    input  logic                      A_rw_i,
    input  logic [XLEN-1:0]           A_data_i,
    input  logic                      A_is_amo_i,
    input  logic [4:0]                A_amo_type_i,
    output logic                      A_data_ready_o,
    output logic [XLEN-1:0]           A_data_o,
    output logic                      M_strobe_o,
    output logic [XLEN-1:0]           M_addr_o,
    output logic                      M_rw_o,
    output logic [XLEN-1:0]           M_data_o,
    input  logic                      M_data_ready_i,
    input  logic [XLEN-1:0]           M_data_i,
    input  logic                      S_wr_strobe_i,
    input  logic [XLEN-1:0]           S_wr_addr_i,
    output logic                      busy_o
);
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
`ifdef AMO_MINMAX_EN
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;
`endif

    typedef enum logic [2:0] {IDLE, READ, COMPUTE, WRITE, DONE} state_t;
    state_t state, state_next;

    logic [CORE_NUMS_BITS-1:0] id_q;
    logic [XLEN-1:0]           rs2_q;
    logic [XLEN-1:0]           old_q;
    logic [4:0]                type_q;
    logic                      is_amo_q;
    logic                      res_valid [CORE_NUMS];
    logic [XLEN-3:0]           res_addr  [CORE_NUMS];

    logic is_sc_req, sc_pass, lr_done, lr_snooped, wr_issue;
    logic unused_snoop_bits;

    function automatic logic is_rmw_op(input logic [4:0] op);
        case (op)
            OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR: is_rmw_op = 1'b1;
`ifdef AMO_MINMAX_EN
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU:       is_rmw_op = 1'b1;
`endif
            default:                                is_rmw_op = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (op)
            OP_SWAP: amo_alu = b;
            OP_ADD:  amo_alu = a + b;
            OP_XOR:  amo_alu = a ^ b;
            OP_AND:  amo_alu = a & b;
            OP_OR:   amo_alu = a | b;
`ifdef AMO_MINMAX_EN
            OP_MIN:  amo_alu = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  amo_alu = ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: amo_alu = (a < b) ? a : b;
            OP_MAXU: amo_alu = (a > b) ? a : b;
`endif
            default: amo_alu = a;
        endcase
    endfunction

    assign is_sc_req  = A_is_amo_i && (A_amo_type_i == OP_SC);
    assign sc_pass    = res_valid[A_id_i] && (res_addr[A_id_i] == A_addr_i[XLEN-1:2]);
    assign lr_done    = (state == READ) && M_data_ready_i && is_amo_q && (type_q == OP_LR);
    assign lr_snooped = S_wr_strobe_i && (S_wr_addr_i[XLEN-1:2] == M_addr_o[XLEN-1:2]);
    assign wr_issue   = (state == WRITE) && M_strobe_o;
    assign busy_o         = (state != IDLE);
    assign A_data_ready_o = (state == DONE);
    assign unused_snoop_bits = ^S_wr_addr_i[1:0];

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (A_strobe_i) begin
                if (is_sc_req)                   state_next = sc_pass ? WRITE : DONE;
                else if (!A_is_amo_i && A_rw_i)  state_next = WRITE;
                else                             state_next = READ;
            end
            READ:    if (M_data_ready_i)
                         state_next = (is_amo_q && is_rmw_op(type_q)) ? COMPUTE : DONE;
            COMPUTE: state_next = WRITE;
            WRITE:   if (M_data_ready_i) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q       <= '0;
            rs2_q      <= '0;
            old_q      <= '0;
            type_q     <= '0;
            is_amo_q   <= 1'b0;
            A_data_o   <= '0;
            M_strobe_o <= 1'b0;
            M_addr_o   <= '0;
            M_rw_o     <= 1'b0;
            M_data_o   <= '0;
        end else begin
            // One-cycle request pulse on every entry into a memory-access state.
            M_strobe_o <= (state_next != state) && ((state_next == READ) || (state_next == WRITE));
            case (state)
                IDLE: if (A_strobe_i) begin
                    id_q     <= A_id_i;
                    rs2_q    <= A_data_i;
                    type_q   <= A_amo_type_i;
                    is_amo_q <= A_is_amo_i;
                    M_addr_o <= A_addr_i;
                    M_data_o <= A_data_i;
                    M_rw_o   <= is_sc_req || (!A_is_amo_i && A_rw_i);
                    if (is_sc_req && !sc_pass) A_data_o <= {{(XLEN-1){1'b0}}, 1'b1};
                end
                READ: if (M_data_ready_i) begin
                    old_q <= M_data_i;
                    if (state_next == DONE) A_data_o <= M_data_i;
                end
                COMPUTE: begin
                    M_data_o <= amo_alu(type_q, old_q, rs2_q);
                    M_rw_o   <= 1'b1;
                end
                WRITE: if (M_data_ready_i)
                    A_data_o <= (is_amo_q && (type_q != OP_SC)) ? old_q : '0;
                default: ;
            endcase
        end
    end

    // NOTE: the reservation table is reset explicitly; a stale valid bit would let an SC pass falsely.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CORE_NUMS; i++) begin
                res_valid[i] <= 1'b0;
                res_addr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CORE_NUMS; i++) begin
                if (lr_done && (id_q == CORE_NUMS_BITS'(i))) begin
                    // A snoop to the same word in the completion cycle wins over the new reservation.
                    res_valid[i] <= !lr_snooped;
                    res_addr[i]  <= M_addr_o[XLEN-1:2];
                end else if ((state == IDLE) && A_strobe_i && is_sc_req &&
                             (A_id_i == CORE_NUMS_BITS'(i))) begin
                    res_valid[i] <= 1'b0;
                end else if ((S_wr_strobe_i && (res_addr[i] == S_wr_addr_i[XLEN-1:2])) ||
                             (wr_issue && (res_addr[i] == M_addr_o[XLEN-1:2]))) begin
                    res_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_amo_rmw_controller.sv
// Self-checking bench for amo_rmw_controller: table-driven AMO vectors, LR/SC and reset sequences,
// a latency-configurable memory responder and a result scoreboard checked on completion.
module tb_amo_rmw_controller;
    localparam int XLEN = 32;
    localparam int CORE_NUMS = 4;
    localparam int CB = 2;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;
    localparam logic [4:0] F_UNK  = 5'b00101;
`ifdef AMO_MINMAX_EN
    localparam logic MM = 1'b1;
`else
    localparam logic MM = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [CB-1:0]   A_id_i = '0;
    logic            A_strobe_i = 1'b0;
    logic [XLEN-1:0] A_addr_i = '0;
    logic            A_rw_i = 1'b0;
    logic [XLEN-1:0] A_data_i = '0;
    logic            A_is_amo_i = 1'b0;
    logic [4:0]      A_amo_type_i = '0;
    logic            A_data_ready_o;
    logic [XLEN-1:0] A_data_o;
    logic            M_strobe_o;
    logic [XLEN-1:0] M_addr_o;
    logic            M_rw_o;
    logic [XLEN-1:0] M_data_o;
    logic            M_data_ready_i = 1'b0;
    logic [XLEN-1:0] M_data_i = '0;
    logic            S_wr_strobe_i = 1'b0;
    logic [XLEN-1:0] S_wr_addr_i = '0;
    logic            busy_o;

    amo_rmw_controller #(.XLEN(XLEN), .CORE_NUMS(CORE_NUMS), .CORE_NUMS_BITS(CB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .A_id_i(A_id_i), .A_strobe_i(A_strobe_i), .A_addr_i(A_addr_i), .A_rw_i(A_rw_i),
        .A_data_i(A_data_i), .A_is_amo_i(A_is_amo_i), .A_amo_type_i(A_amo_type_i),
        .A_data_ready_o(A_data_ready_o), .A_data_o(A_data_o),
        .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
        .M_data_ready_i(M_data_ready_i), .M_data_i(M_data_i),
        .S_wr_strobe_i(S_wr_strobe_i), .S_wr_addr_i(S_wr_addr_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [4:0] op; logic [31:0] init; logic [31:0] rs2; logic [31:0] mem_exp; logic rmw; } vec_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    logic [31:0] mem[0:1023];
    int n_cmp = 0, n_err = 0, cyc = 0;
    int rd_lat = 1, wr_lat = 1, m_cnt = 0, wr_cnt = 0, wr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    // Memory model: ready arrives (latency-1) cycles after the request pulse.
    initial forever begin
        logic [31:0] a, d;
        logic w;
        int lat;
        @(negedge clk_i);
        M_data_ready_i = 1'b0;
        if (M_strobe_o) begin
            a = M_addr_o; w = M_rw_o; d = M_data_o;
            lat = w ? wr_lat : rd_lat;
            m_cnt++;
            if (w) begin wr_cnt++; wr_cyc = cyc; end
            for (int k = 1; k < lat; k++) @(negedge clk_i);
            if (w) mem[a[11:2]] = d;
            else   M_data_i = mem[a[11:2]];
            M_data_ready_i = 1'b1;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (!rst_i && A_data_ready_o) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_ready: got completion with A_data_o=%h, expected none", A_data_o);
            end else begin
                e = sb.pop_front();
                check("result", A_data_o, e.data);
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic start_req(input logic [CB-1:0] id, input logic [31:0] addr, input logic rw,
                             input logic [31:0] data, input logic is_amo, input logic [4:0] typ,
                             input logic [31:0] exp_data, input int exp_lat, input logic expect_done,
                             output int t);
        exp_t e;
        @(posedge clk_i); #1;
        A_id_i = id; A_addr_i = addr; A_rw_i = rw; A_data_i = data;
        A_is_amo_i = is_amo; A_amo_type_i = typ; A_strobe_i = 1'b1;
        t = cyc;
        if (expect_done) begin
            e.data = exp_data; e.cyc = cyc + exp_lat;
            sb.push_back(e);
        end
        @(posedge clk_i); #1;
        A_strobe_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk_i); #1;
    endtask

    task automatic req(input logic [CB-1:0] id, input logic [31:0] addr, input logic rw,
                       input logic [31:0] data, input logic is_amo, input logic [4:0] typ,
                       input logic [31:0] exp_data, input int exp_lat);
        int t;
        start_req(id, addr, rw, data, is_amo, typ, exp_data, exp_lat, 1'b1, t);
        wait_done();
    endtask

    task automatic snoop(input logic [31:0] addr);
        S_wr_addr_i = addr; S_wr_strobe_i = 1'b1;
        @(posedge clk_i); #1;
        S_wr_strobe_i = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        int t, lat, w0, m0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        vecs[0] = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        vecs[1] = '{F_SWAP, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE, 1'b1};
        vecs[2] = '{F_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1};
        vecs[3] = '{F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1};
        vecs[4] = '{F_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1};
        vecs[5] = '{F_MIN,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, MM};
        vecs[6] = '{F_MINU, 32'hFFFFFFFF, 32'h00000001, MM ? 32'h00000001 : 32'hFFFFFFFF, MM};
        vecs[7] = '{F_MAX,  32'h80000000, 32'h00000005, MM ? 32'h00000005 : 32'h80000000, MM};
        vecs[8] = '{F_MAXU, 32'h80000000, 32'h00000005, 32'h80000000, MM};
        vecs[9] = '{F_UNK,  32'hAAAA5555, 32'h00000001, 32'hAAAA5555, 1'b0};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ctrl", {28'h0, A_data_ready_o, M_strobe_o, M_rw_o, busy_o}, 32'h0);
        check("reset_a_data", A_data_o, 32'h0);
        check("reset_m_addr", M_addr_o, 32'h0);
        check("reset_m_data", M_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            addr = 32'h100 + 32'(4 * i);
            rd_lat = 1 + i % 3;
            wr_lat = 1 + i % 2;
            mem[addr[11:2]] = vecs[i].init;
            w0 = wr_cnt;
            lat = vecs[i].rmw ? 2 + rd_lat + wr_lat : 1 + rd_lat;
            start_req(CB'((i + 2) % 4), addr, 1'b0, vecs[i].rs2, 1'b1, vecs[i].op,
                      vecs[i].init, lat, 1'b1, t);
            wait_done();
            check("vec_mem", mem[addr[11:2]], vecs[i].mem_exp);
            if (vecs[i].rmw) check("vec_wr_strobe_cycle", wr_cyc, t + 2 + rd_lat);
            else             check("vec_no_write", wr_cnt, w0);
        end

        rd_lat = 2; wr_lat = 3;
        addr = 32'h200; mem[addr[11:2]] = 32'd5;
        req(0, 32'h200, 1'b0, 32'd0, 1'b1, F_LR, 32'd5, 3);
        req(0, 32'h200, 1'b0, 32'd9, 1'b1, F_SC, 32'd0, 4);
        check("sc_pass_mem", mem[addr[11:2]], 32'd9);
        req(0, 32'h200, 1'b0, 32'd4, 1'b1, F_SC, 32'd1, 1);
        check("sc_reuse_mem", mem[addr[11:2]], 32'd9);

        addr = 32'h300; mem[addr[11:2]] = 32'h33;
        req(1, 32'h300, 1'b0, 32'd0, 1'b1, F_LR, 32'h33, 3);
        @(posedge clk_i); #1;
        snoop(32'h302);
        m0 = m_cnt;
        req(1, 32'h300, 1'b0, 32'd7, 1'b1, F_SC, 32'd1, 1);
        check("sc_fail_no_mem_access", m_cnt, m0);

        addr = 32'h400; mem[addr[11:2]] = 32'h44;
        addr = 32'h404; mem[addr[11:2]] = 32'h48;
        req(0, 32'h400, 1'b0, 32'd0, 1'b1, F_LR, 32'h44, 3);
        req(3, 32'h400, 1'b0, 32'd0, 1'b1, F_LR, 32'h44, 3);
        req(1, 32'h404, 1'b0, 32'd0, 1'b1, F_LR, 32'h48, 3);
        req(2, 32'h400, 1'b0, 32'h77, 1'b1, F_SWAP, 32'h44, 7);
        req(0, 32'h400, 1'b0, 32'h1, 1'b1, F_SC, 32'd1, 1);
        req(3, 32'h400, 1'b0, 32'h2, 1'b1, F_SC, 32'd1, 1);
        req(1, 32'h404, 1'b0, 32'h99, 1'b1, F_SC, 32'd0, 4);
        addr = 32'h400; check("swap_mem", mem[addr[11:2]], 32'h77);
        addr = 32'h404; check("neighbour_sc_mem", mem[addr[11:2]], 32'h99);

        req(0, 32'h600, 1'b1, 32'hDEAD, 1'b0, F_ADD, 32'd0, 4);
        addr = 32'h600; check("plain_write_mem", mem[addr[11:2]], 32'hDEAD);
        req(1, 32'h600, 1'b0, 32'd0, 1'b0, F_ADD, 32'hDEAD, 3);

        addr = 32'h700; mem[addr[11:2]] = 32'h7;
        start_req(2, 32'h700, 1'b0, 32'd0, 1'b1, F_LR, 32'h7, 3, 1'b1, t);
        @(posedge clk_i); #1;
        snoop(32'h700);
        wait_done();
        req(2, 32'h700, 1'b0, 32'h70, 1'b1, F_SC, 32'd1, 1);

        addr = 32'h800; mem[addr[11:2]] = 32'h88;
        req(3, 32'h800, 1'b0, 32'd0, 1'b1, F_LR, 32'h88, 3);
        start_req(3, 32'h800, 1'b0, 32'hAB, 1'b1, F_SC, 32'd0, 4, 1'b1, t);
        snoop(32'h800);
        wait_done();
        check("sc_after_snoop_mem", mem[addr[11:2]], 32'hAB);

        rd_lat = 1; wr_lat = 4;
        addr = 32'hA00; mem[addr[11:2]] = 32'hA0;
        req(0, 32'hA00, 1'b0, 32'd0, 1'b1, F_LR, 32'hA0, 2);
        addr = 32'h900; mem[addr[11:2]] = 32'd1;
        start_req(1, 32'h900, 1'b0, 32'd1, 1'b1, F_ADD, 32'd0, 0, 1'b0, t);
        repeat (2) @(posedge clk_i);
        #1;
        check("write_in_flight", {29'h0, busy_o, M_strobe_o, M_rw_o}, 32'h7);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midop_reset_ctrl", {28'h0, A_data_ready_o, M_strobe_o, M_rw_o, busy_o}, 32'h0);
        check("midop_reset_a_data", A_data_o, 32'h0);
        check("midop_reset_m_data", M_data_o, 32'h0);
        repeat (8) @(posedge clk_i);
        #1;
        req(0, 32'hA00, 1'b0, 32'd5, 1'b1, F_SC, 32'd1, 1);
        req(0, 32'hA00, 1'b0, 32'd0, 1'b1, F_LR, 32'hA0, 2);
        req(0, 32'hA00, 1'b0, 32'd5, 1'b1, F_SC, 32'd0, 5);
        addr = 32'hA00; check("post_reset_sc_mem", mem[addr[11:2]], 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
